// File: rtl/fifo_to_mem_nq_pkg.sv
// rtl/fifo_to_mem_nq_pkg.sv - shared types and parameter helpers for the multi-queue FIFO-to-QDR writer
package fifo_to_mem_nq_pkg;

  // Entry sequencing: IDLE decides on the FIFO head, BEAT walks the remaining beats of one entry
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BEAT = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so single-element selects still get a bit
  function automatic int f_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Memory beats (dwl/dwh pairs) carried by one FIFO entry
  function automatic int f_beats(input int fifo_w, input int mem_w);
    return fifo_w / (2 * mem_w);
  endfunction

  // Beats sharing one memory address
  function automatic int f_bpa(input int burst_len);
    return burst_len / 2;
  endfunction

endpackage

// File: rtl/fifo_to_mem_nq_if.sv
// rtl/fifo_to_mem_nq_if.sv - FIFO pop side and QDR write side of the writer
interface fifo_to_mem_nq_if #(
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int QW              = 2,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 36
);
  logic                        fifo_rd_en;
  logic [FIFO_DATA_WIDTH-1:0]  fifo_data;
  logic [QW-1:0]               fifo_qid;
  logic                        fifo_empty;
  logic                        mem_wr_full;
  logic                        mem_ad_w_n;
  logic                        mem_d_w_n;
  logic [MEM_ADDR_WIDTH-1:0]   mem_ad_wr;
  logic [MEM_DATA_WIDTH/9-1:0] mem_bwh_n;
  logic [MEM_DATA_WIDTH/9-1:0] mem_bwl_n;
  logic [MEM_DATA_WIDTH-1:0]   mem_dwl;
  logic [MEM_DATA_WIDTH-1:0]   mem_dwh;

  modport master (
    output fifo_rd_en, mem_ad_w_n, mem_d_w_n, mem_ad_wr, mem_bwh_n, mem_bwl_n, mem_dwl, mem_dwh,
    input  fifo_data, fifo_qid, fifo_empty, mem_wr_full
  );

  modport slave (
    input  fifo_rd_en, mem_ad_w_n, mem_d_w_n, mem_ad_wr, mem_bwh_n, mem_bwl_n, mem_dwl, mem_dwh,
    output fifo_data, fifo_qid, fifo_empty, mem_wr_full
  );
endinterface

// File: rtl/fifo_to_mem_nq_qptr.sv
// rtl/fifo_to_mem_nq_qptr.sv - one queue's beat pointer, sticky full flag and entry counter
module fifo_to_mem_nq_qptr #(
  parameter int AW  = 19,
  parameter int PW  = 21,
  parameter int BPA = 1,
  parameter int CW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ad_low,
  input  logic [AW-1:0] ad_high,
  input  logic          inc,
  input  logic          wrap,
  input  logic          setfull,
  input  logic          cnt_inc,
  output logic [PW-1:0] ptr,
  output logic          at_high,
  output logic          full,
  output logic [CW-1:0] entry_cnt
);
  logic          full_r;
  logic [PW-1:0] lo_b;
  logic [PW-1:0] hi_b;

  // Region bounds in beat units; an empty or inverted region behaves as permanently full
  always_comb begin
    lo_b    = PW'(ad_low) * PW'(BPA);
    hi_b    = PW'(ad_high) * PW'(BPA);
    at_high = (ptr == hi_b);
    full    = full_r | (ad_high <= ad_low);
  end

  // Pointer advance/wrap, sticky full and entry count, driven by strobes from the sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= lo_b;
      full_r    <= 1'b0;
      entry_cnt <= '0;
    end else begin
      if (wrap)         ptr <= lo_b;
      else if (inc)     ptr <= ptr + 1'b1;
      if (setfull)      full_r <= 1'b1;
      if (cnt_inc)      entry_cnt <= entry_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_to_mem_nq.sv
// rtl/fifo_to_mem_nq.sv - pops tagged FIFO entries and writes them as beats into per-queue regions
module fifo_to_mem_nq
  import fifo_to_mem_nq_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = 144,
  parameter int NUM_QUEUES       = 4,
  parameter int MEM_ADDR_WIDTH   = 19,
  parameter int MEM_DATA_WIDTH   = 36,
  parameter int MEM_BURST_LENGTH = 2,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sw_rst,
  input  logic                               cal_done,
  fifo_to_mem_nq_if.master                   bus,
  input  logic [NUM_QUEUES-1:0]              q_enable,
  input  logic [NUM_QUEUES-1:0]              q_wrap,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_ad_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_ad_high,
  output logic [NUM_QUEUES-1:0]              q_full,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]    q_entry_cnt
);
  localparam int QW    = f_log2(NUM_QUEUES);
  localparam int BEATS = f_beats(FIFO_DATA_WIDTH, MEM_DATA_WIDTH);
  localparam int BPA   = f_bpa(MEM_BURST_LENGTH);
  localparam int KW    = f_log2(BEATS);
  localparam int PW    = MEM_ADDR_WIDTH + 2;

  state_t                state;
  logic [KW-1:0]         beat_k;
  logic [QW-1:0]         cur_q;
  logic [PW-1:0]         ptr [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] at_high, full_v, inc_v, wrap_v, setfull_v, cnt_v;
  logic                  go, idle_act, head_ok, head_drop, beat_issue, last_beat;
  logic [QW-1:0]         act_q;
  logic [KW-1:0]         cur_k;
  logic [PW-1:0]         cur_ptr, cur_addr;

  // Head decision, beat issue and per-queue strobes; the pop must be combinational for the FWFT FIFO
  always_comb begin
    go         = cal_done & ~bus.mem_wr_full;
    head_ok    = (int'(bus.fifo_qid) < NUM_QUEUES);
    idle_act   = (state == ST_IDLE) & ~bus.fifo_empty & go;
    head_drop  = ~head_ok | ~q_enable[bus.fifo_qid] | full_v[bus.fifo_qid];
    act_q      = (state == ST_IDLE) ? bus.fifo_qid : cur_q;
    cur_k      = (state == ST_IDLE) ? '0 : beat_k;
    last_beat  = (int'(cur_k) == BEATS - 1);
    beat_issue = (idle_act & ~head_drop & ~at_high[bus.fifo_qid]) | ((state == ST_BEAT) & go);
    cur_ptr    = ptr[act_q];
    cur_addr   = cur_ptr / PW'(BPA);
    inc_v      = '0;
    wrap_v     = '0;
    setfull_v  = '0;
    cnt_v      = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (int'(act_q) == i) begin
        inc_v[i]     = beat_issue;
        cnt_v[i]     = beat_issue & last_beat;
        wrap_v[i]    = idle_act & ~head_drop & at_high[i] & q_wrap[i];
        setfull_v[i] = idle_act & ~head_drop & at_high[i] & ~q_wrap[i];
      end
    end
    bus.fifo_rd_en = (idle_act & head_drop) | (beat_issue & last_beat);
  end

  assign bus.mem_bwh_n = '0;
  assign bus.mem_bwl_n = '0;
  assign q_full        = full_v;

  // Entry sequencer with registered memory outputs; strobes only on the first beat of each address
  always_ff @(posedge clk) begin
    if (rst | sw_rst) begin
      state          <= ST_IDLE;
      beat_k         <= '0;
      cur_q          <= '0;
      bus.mem_ad_w_n <= 1'b1;
      bus.mem_d_w_n  <= 1'b1;
      bus.mem_ad_wr  <= '0;
      bus.mem_dwl    <= '0;
      bus.mem_dwh    <= '0;
    end else begin
      bus.mem_ad_w_n <= 1'b1;
      bus.mem_d_w_n  <= 1'b1;
      if (beat_issue) begin
        bus.mem_ad_wr  <= cur_addr[MEM_ADDR_WIDTH-1:0];
        bus.mem_ad_w_n <= ((cur_ptr % PW'(BPA)) != '0);
        bus.mem_d_w_n  <= ((cur_ptr % PW'(BPA)) != '0);
        bus.mem_dwl    <= bus.fifo_data[int'(cur_k)*2*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        bus.mem_dwh    <= bus.fifo_data[int'(cur_k)*2*MEM_DATA_WIDTH + MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end
      case (state)
        ST_IDLE: begin
          if (idle_act) begin
            cur_q <= bus.fifo_qid;
            if (beat_issue && BEATS > 1) begin
              state  <= ST_BEAT;
              beat_k <= KW'(1);
            end
          end
        end
        ST_BEAT: begin
          if (go) begin
            if (last_beat) begin
              state  <= ST_IDLE;
              beat_k <= '0;
            end else begin
              beat_k <= beat_k + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
    fifo_to_mem_nq_qptr #(
      .AW (MEM_ADDR_WIDTH),
      .PW (PW),
      .BPA(BPA),
      .CW (CNT_WIDTH)
    ) u_qptr (
      .clk      (clk),
      .rst      (rst | sw_rst),
      .ad_low   (q_ad_low[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]),
      .ad_high  (q_ad_high[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH]),
      .inc      (inc_v[i]),
      .wrap     (wrap_v[i]),
      .setfull  (setfull_v[i]),
      .cnt_inc  (cnt_v[i]),
      .ptr      (ptr[i]),
      .at_high  (at_high[i]),
      .full     (full_v[i]),
      .entry_cnt(q_entry_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule
